// File: rtl/ad9783_spi_pkg.sv
// Shared types and field positions for the AD9783 serial-port responder.
// The readback path in the top level is enabled by AD9783_SPI_READBACK_EN.
package ad9783_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INSTR = 2'd1,
    ST_DATA  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int RW_BIT       = 7;
  localparam int N_MSB        = 6;
  localparam int N_LSB        = 5;
  localparam int ADDR_W       = 5;
  localparam int REG_COUNT    = 32;
  localparam int SOFT_RST_BIT = 5;
  localparam logic [ADDR_W-1:0] SOFT_RST_ADDR = 5'h00;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, followed by an
// edge-detect register producing one-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ad9783_spi_responder.sv
// AD9783 serial-port responder: instruction decode, 32x8 register file,
// write export. Define AD9783_SPI_READBACK_EN to drive read data on SDO.
module ad9783_spi_responder
  import ad9783_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              spi_scs_in,
  input  logic              spi_sck_in,
  input  logic              spi_sdi_in,
  output logic              spi_sdo_out,
  output logic              spi_sdo_oe_out,
  output logic              wr_strobe_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [7:0]        wr_data_out,
  input  logic [ADDR_W-1:0] loc_addr_in,
  output logic [7:0]        loc_data_out,
  output logic              busy_out,
  output state_t            state_dbg_out
);

  logic sck_level, sck_rise, sck_fall;
  logic csb_level, csb_rise, csb_fall;
  logic sdi_level, sdi_rise, sdi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk_in), .rst_n(rst_in), .pin(spi_sck_in),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );

  // CSB resets to "selected" so a reset released mid-transfer cannot see a
  // false falling edge; only a genuine rise-then-fall starts a transaction.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_csb (
    .clk(clk_in), .rst_n(rst_in), .pin(spi_scs_in),
    .level(csb_level), .rise(csb_rise), .fall(csb_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi (
    .clk(clk_in), .rst_n(rst_in), .pin(spi_sdi_in),
    .level(sdi_level), .rise(sdi_rise), .fall(sdi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sck_level, csb_level, sdi_rise, sdi_fall};

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_in_q;
  logic              rw_q;
  logic [1:0]        bytes_left_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_strobe_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              soft_rst_q;
  logic [7:0]        regs_q [REG_COUNT];

  logic       sck_rise_ok, shift_en, instr_done, data_done, commit;
  logic [7:0] next_byte, commit_data;

  // A CSB rise outranks an SCK rise recognised in the same cycle.
  assign sck_rise_ok = sck_rise & ~csb_rise;
  assign next_byte   = {shift_in_q[6:0], sdi_level};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (csb_fall) state_d = ST_INSTR;
      ST_INSTR: if (instr_done) state_d = ST_DATA;
      ST_DATA:  if (data_done && bytes_left_q == 2'd0) state_d = ST_HOLD;
      ST_HOLD:  state_d = ST_HOLD;
      default:  state_d = ST_IDLE;
    endcase
    if (csb_rise) state_d = ST_IDLE;
  end

  always_comb begin
    busy_out    = (state_q != ST_IDLE);
    shift_en    = sck_rise_ok && (state_q == ST_INSTR || state_q == ST_DATA);
    instr_done  = shift_en && (state_q == ST_INSTR) && (bit_cnt_q == 3'd7);
    data_done   = shift_en && (state_q == ST_DATA) && (bit_cnt_q == 3'd7);
    commit      = data_done && !rw_q;
    commit_data = next_byte;
    if (addr_q == SOFT_RST_ADDR) commit_data[SOFT_RST_BIT] = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bit_cnt_q    <= '0;
      shift_in_q   <= '0;
      rw_q         <= 1'b0;
      bytes_left_q <= '0;
      addr_q       <= '0;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      soft_rst_q   <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else begin
      wr_strobe_q <= commit;
      soft_rst_q  <= commit && (addr_q == SOFT_RST_ADDR) && next_byte[SOFT_RST_BIT];
      if (commit) begin
        wr_addr_q <= addr_q;
        wr_data_q <= next_byte;
      end
      if (csb_rise || (state_q == ST_IDLE && csb_fall)) begin
        bit_cnt_q <= '0;
      end else if (shift_en) begin
        bit_cnt_q  <= bit_cnt_q + 3'd1;
        shift_in_q <= next_byte;
      end
      if (instr_done) begin
        rw_q         <= next_byte[RW_BIT];
        bytes_left_q <= next_byte[N_MSB:N_LSB];
        addr_q       <= next_byte[ADDR_W-1:0];
      end
      if (data_done) begin
        addr_q       <= addr_q - 5'd1;
        bytes_left_q <= bytes_left_q - 2'd1;
      end
      if (soft_rst_q) begin
        for (int i = 1; i < REG_COUNT; i++) regs_q[i] <= '0;
      end
      if (commit) regs_q[addr_q] <= commit_data;
    end
  end

`ifdef AD9783_SPI_READBACK_EN
  logic [7:0]        shift_out_q;
  logic              sdo_q, sdo_oe_q;
  logic [ADDR_W-1:0] rd_addr;

  assign rd_addr = instr_done ? next_byte[ADDR_W-1:0] : addr_q - 5'd1;

  // The next read byte is loaded on the rise that completes the previous
  // byte (or the instruction), ready for the following SCK fall.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      shift_out_q <= '0;
      sdo_q       <= 1'b0;
      sdo_oe_q    <= 1'b0;
    end else begin
      if (csb_rise || state_q == ST_HOLD || state_q == ST_IDLE) begin
        sdo_q    <= 1'b0;
        sdo_oe_q <= 1'b0;
      end else if (sck_fall && state_q == ST_DATA && rw_q) begin
        sdo_q       <= shift_out_q[7];
        shift_out_q <= {shift_out_q[6:0], 1'b0};
        sdo_oe_q    <= 1'b1;
      end
      if ((instr_done && next_byte[RW_BIT]) || (data_done && rw_q)) begin
        shift_out_q <= regs_q[rd_addr];
      end
    end
  end

  assign spi_sdo_out    = sdo_q;
  assign spi_sdo_oe_out = sdo_oe_q;
`else
  logic unused_rd;
  assign unused_rd      = sck_fall;
  assign spi_sdo_out    = 1'b0;
  assign spi_sdo_oe_out = 1'b0;
`endif

  assign wr_strobe_out = wr_strobe_q;
  assign wr_addr_out   = wr_addr_q;
  assign wr_data_out   = wr_data_q;
  assign loc_data_out  = regs_q[loc_addr_in];
  assign state_dbg_out = state_q;

endmodule

// File: tb/tb_ad9783_spi_responder.sv
// Directed bench for ad9783_spi_responder: writes, streaming, readback,
// abort, address wrap, soft reset and asynchronous reset mid-transfer.
module tb_ad9783_spi_responder;
  import ad9783_spi_pkg::*;

  localparam int HALF = 8;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       csb = 1'b1;
  logic       sck = 1'b0;
  logic       sdi = 1'b0;
  logic [4:0] loc_addr = '0;
  logic       sdo, sdo_oe, wr_strobe, busy;
  logic [4:0] wr_addr;
  logic [7:0] wr_data, loc_data;
  state_t     state_dbg;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];
  logic [12:0] mon_exp;

  always #5 clk_in = ~clk_in;

  ad9783_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .spi_scs_in(csb), .spi_sck_in(sck), .spi_sdi_in(sdi),
    .spi_sdo_out(sdo), .spi_sdo_oe_out(sdo_oe),
    .wr_strobe_out(wr_strobe), .wr_addr_out(wr_addr), .wr_data_out(wr_data),
    .loc_addr_in(loc_addr), .loc_data_out(loc_data),
    .busy_out(busy), .state_dbg_out(state_dbg)
  );

  // Scoreboard: every strobe must match the head of the expected queue.
  always @(negedge clk_in) begin
    if (rst_in && wr_strobe) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected got addr=%h data=%h, expected no strobe", wr_addr, wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({wr_addr, wr_data} !== mon_exp) begin
          errors++;
          $display("FAIL strobe got addr=%h data=%h, expected addr=%h data=%h",
                   wr_addr, wr_data, mon_exp[12:8], mon_exp[7:0]);
        end
      end
    end
  end

  task automatic sck_bit(input logic b, output logic sdo_s, output logic oe_s);
    sdi = b;
    repeat (HALF) @(negedge clk_in);
    sdo_s = sdo;
    oe_s  = sdo_oe;
    sck = 1'b1;
    repeat (HALF) @(negedge clk_in);
    sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] rd, inout int oe_cnt);
    logic s, o;
    for (int i = 7; i >= 0; i--) begin
      sck_bit(b[i], s, o);
      rd[i] = s;
      if (o) oe_cnt++;
    end
  endtask

  task automatic csb_start();
    csb = 1'b0;
    repeat (HALF) @(negedge clk_in);
  endtask

  task automatic csb_end();
    repeat (HALF) @(negedge clk_in);
    csb = 1'b1;
    repeat (2 * HALF) @(negedge clk_in);
  endtask

  task automatic txn_body(input logic [7:0] instr, input int n, input logic [31:0] wd,
                          output logic [31:0] rd, output int oe_cnt);
    logic [7:0] r;
    oe_cnt = 0;
    rd = '0;
    send_byte(instr, r, oe_cnt);
    for (int k = 0; k < n; k++) begin
      send_byte(wd[31-8*k -: 8], r, oe_cnt);
      rd[31-8*k -: 8] = r;
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (4) @(negedge clk_in);
    checks++; if (sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo got %b expected 0", sdo); end
    checks++; if (sdo_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b expected 0", sdo_oe); end
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b expected 0", wr_strobe); end
    checks++; if ({wr_addr, wr_data} !== 13'h0) begin errors++; $display("FAIL reset_wr got %h/%h expected 00/00", wr_addr, wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    loc_addr = 5'h1F; #1;
    checks++; if (loc_data !== 8'h00) begin errors++; $display("FAIL reset_reg1f got %h expected 00", loc_data); end
    rst_in = 1'b1;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic test_single_write();
    logic [31:0] rd; int oe_cnt;
    exp_q.push_back({5'h02, 8'hA5});
    csb_start(); txn_body(8'h02, 1, 32'hA500_0000, rd, oe_cnt); csb_end();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_write_strobes got %0d pending expected 0", exp_q.size()); end
    loc_addr = 5'h02; #1;
    checks++; if (loc_data !== 8'hA5) begin errors++; $display("FAIL single_write_reg got %h expected a5", loc_data); end
  endtask

  task automatic test_stream();
    logic [31:0] rd; int oe_cnt; logic s, o;
    exp_q.push_back({5'h05, 8'h11});
    exp_q.push_back({5'h04, 8'h22});
    exp_q.push_back({5'h03, 8'h33});
    exp_q.push_back({5'h02, 8'h44});
    csb_start(); txn_body(8'h65, 4, 32'h1122_3344, rd, oe_cnt);
    checks++; if (state_dbg !== ST_HOLD) begin errors++; $display("FAIL stream_hold got %0d expected %0d", state_dbg, ST_HOLD); end
    for (int i = 0; i < 8; i++) sck_bit(1'b1, s, o);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stream_hold_busy got %b expected 1", busy); end
    csb_end();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_strobes got %0d pending expected 0", exp_q.size()); end
    loc_addr = 5'h05; #1;
    checks++; if (loc_data !== 8'h11) begin errors++; $display("FAIL stream_reg05 got %h expected 11", loc_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_idle got %b expected 0", busy); end
  endtask

  task automatic test_read();
    logic [31:0] rd; int oe_cnt;
    logic [7:0] exp_rd; int exp_oe;
`ifdef AD9783_SPI_READBACK_EN
    exp_rd = 8'hA5; exp_oe = 8;
`else
    exp_rd = 8'h00; exp_oe = 0;
`endif
    exp_q.push_back({5'h02, 8'hA5});
    csb_start(); txn_body(8'h02, 1, 32'hA500_0000, rd, oe_cnt); csb_end();
    csb_start(); txn_body(8'h82, 1, 32'h5A00_0000, rd, oe_cnt); csb_end();
    checks++; if (rd[31:24] !== exp_rd) begin errors++; $display("FAIL read_sdo got %h expected %h", rd[31:24], exp_rd); end
    checks++; if (oe_cnt != exp_oe) begin errors++; $display("FAIL read_oe_bits got %0d expected %0d", oe_cnt, exp_oe); end
    checks++; if (sdo_oe !== 1'b0) begin errors++; $display("FAIL read_oe_after got %b expected 0", sdo_oe); end
    loc_addr = 5'h02; #1;
    checks++; if (loc_data !== 8'hA5) begin errors++; $display("FAIL read_reg_kept got %h expected a5", loc_data); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL read_strobes got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_abort();
    logic [7:0] r; int oe_cnt; logic s, o;
    oe_cnt = 0;
    csb_start();
    send_byte(8'h03, r, oe_cnt);
    for (int i = 0; i < 4; i++) sck_bit(1'b1, s, o);
    csb_end();
    loc_addr = 5'h03; #1;
    checks++; if (loc_data !== 8'h33) begin errors++; $display("FAIL abort_reg03 got %h expected 33", loc_data); end
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL abort_state got %0d expected %0d", state_dbg, ST_IDLE); end
  endtask

  task automatic test_wrap_soft_reset();
    logic [31:0] rd; int oe_cnt;
    exp_q.push_back({5'h01, 8'h77});
    exp_q.push_back({5'h00, 8'h00});
    csb_start(); txn_body(8'h21, 2, 32'h7700_0000, rd, oe_cnt); csb_end();
    loc_addr = 5'h01; #1;
    checks++; if (loc_data !== 8'h77) begin errors++; $display("FAIL wrap_reg01 got %h expected 77", loc_data); end
    loc_addr = 5'h00; #1;
    checks++; if (loc_data !== 8'h00) begin errors++; $display("FAIL wrap_reg00 got %h expected 00", loc_data); end
    exp_q.push_back({5'h00, 8'h20});
    csb_start(); txn_body(8'h00, 1, 32'h2000_0000, rd, oe_cnt); csb_end();
    loc_addr = 5'h01; #1;
    checks++; if (loc_data !== 8'h00) begin errors++; $display("FAIL soft_rst_reg01 got %h expected 00", loc_data); end
    loc_addr = 5'h05; #1;
    checks++; if (loc_data !== 8'h00) begin errors++; $display("FAIL soft_rst_reg05 got %h expected 00", loc_data); end
    loc_addr = 5'h00; #1;
    checks++; if (loc_data !== 8'h00) begin errors++; $display("FAIL soft_rst_bit5 got %h expected 00", loc_data); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_strobes got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int oe_cnt; logic [7:0] r; logic s, o;
    exp_q.push_back({5'h07, 8'h5A});
    csb_start(); txn_body(8'h07, 1, 32'h5A00_0000, rd, oe_cnt); csb_end();
    loc_addr = 5'h07; #1;
    checks++; if (loc_data !== 8'h5A) begin errors++; $display("FAIL mid_pre_reg07 got %h expected 5a", loc_data); end
    oe_cnt = 0;
    csb_start();
    send_byte(8'h04, r, oe_cnt);
    sck_bit(1'b1, s, o);
    sck_bit(1'b1, s, o);
    sdi = 1'b1;
    repeat (HALF) @(negedge clk_in);
    sck = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b expected 0", busy); end
    checks++; if ({wr_addr, wr_data} !== 13'h0) begin errors++; $display("FAIL mid_wr got %h/%h expected 00/00", wr_addr, wr_data); end
    checks++; if ({sdo, sdo_oe, wr_strobe} !== 3'b000) begin errors++; $display("FAIL mid_outs got %b expected 000", {sdo, sdo_oe, wr_strobe}); end
    checks++; if (loc_data !== 8'h00) begin errors++; $display("FAIL mid_reg07 got %h expected 00", loc_data); end
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (HALF) @(negedge clk_in);
    sck = 1'b0;
    for (int i = 0; i < 5; i++) sck_bit(1'b1, s, o);
    csb_end();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_ignored got %b expected 0", busy); end
    exp_q.push_back({5'h04, 8'h3C});
    csb_start(); txn_body(8'h04, 1, 32'h3C00_0000, rd, oe_cnt); csb_end();
    loc_addr = 5'h04; #1;
    checks++; if (loc_data !== 8'h3C) begin errors++; $display("FAIL mid_after_reg04 got %h expected 3c", loc_data); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_strobes got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_stream();
    test_read();
    test_abort();
    test_wrap_soft_reset();
    test_reset_mid();
    repeat (4) @(negedge clk_in);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad9783_spi_responder.md
# ad9783_spi_responder

Oversampled SPI responder implementing the AD9783 serial-port protocol: decodes the instruction byte, streams data bytes into or out of a 32 x 8 register file, and exports register writes to local logic. It sits on the far side of the AD9783 driver's SPI bus (`spi_scs_out`/`spi_sck_out`/`spi_sdi_in`) in loopback benches and DAC-emulation builds. Configuration sequences issued by the driver can be checked against a known register image without hardware.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of the SPI input synchronizers (legal 2..4).
- `clk_in`  in  1  system clock; all logic on its rising edge.
- `rst_in`  in  1  asynchronous, active-low reset.
- `spi_scs_in`  in  1  chip select, active low.
- `spi_sck_in`  in  1  SPI clock, idle low; data sampled on SCK rise.
- `spi_sdi_in`  in  1  serial data from the master, MSB first.
- `spi_sdo_out`  out  1  serial read data, MSB first.
- `spi_sdo_oe_out`  out  1  high while read data is driven.
- `wr_strobe_out`  out  1  one-cycle pulse per committed write byte.
- `wr_addr_out`  out  5  address of the committed byte.
- `wr_data_out`  out  8  committed data.
- `loc_addr_in`  in  5  local read address.
- `loc_data_out`  out  8  register contents at `loc_addr_in`, combinational.
- `busy_out`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, INSTR, DATA, HOLD.
- IDLE -> INSTR on synchronized CSB falling; bit counter cleared.
- INSTR: shift 8 bits on SCK rises. Instruction layout:
  - bit7 R/W, 1 = read.
  - bits6:5 N, transfer N+1 bytes.
  - bits4:0 start address.
- After the 8th bit, latch rw/N/address, then go to DATA.
- DATA write: each 8-bit byte commits to `reg[addr]` and pulses `wr_strobe_out`.
- DATA read: `reg[addr]` loads into the shift register on the 8th instruction rise; bits shift out on SCK falls.
- Address decrements after each byte; 0x00 wraps to 0x1F.
- After N+1 bytes -> HOLD. In HOLD, SCK is ignored and SDO is held low/undriven until CSB rises.
- CSB rising, from any state -> IDLE. A partial byte is discarded; no strobe, no register change.
- Register 0x00 bit5 is soft reset. Writing 1 clears registers 0x01..0x1F to 0x00 on the next cycle; bit5 self-clears in the same cycle. Other bits of 0x00 store normally.
- Register reset values: all 0x00.
- Output reset values:
  - `spi_sdo_out`=0, `spi_sdo_oe_out`=0, `wr_strobe_out`=0.
  - `wr_addr_out`=0, `wr_data_out`=0, `busy_out`=0.
- Assertion of `rst_in` mid-transfer forces IDLE and clears all registers immediately. SPI activity before the next CSB fall is ignored.

## Timing
- Input path: `SYNC_STAGES` flops, then an edge-detect register.
- An SCK/CSB edge is recognised `SYNC_STAGES`+1 clk_in cycles after the pin edge.
- Requirements on the master:
  - SCK high and low phases each at least `SYNC_STAGES`+2 clk_in cycles.
  - CSB setup/hold to SCK at least the same.
- `wr_strobe_out` is asserted exactly 1 cycle after the 8th data-bit rise is recognised. `wr_addr_out`/`wr_data_out` are valid in that same cycle and held until the next strobe.
- SDO update: 1 cycle after a recognised SCK fall. The first read bit is driven after the SCK fall following the 8th instruction bit.
- `spi_sdo_oe_out` rises with the first read bit. It falls 1 cycle after the HOLD transition or after CSB rise is recognised.
- A CSB rise and an SCK rise recognised in the same cycle: the CSB rise wins and the bit is discarded.

## Configuration
- `AD9783_SPI_READBACK_EN` defined: read transactions drive SDO as above.
- Undefined:
  - The read shifter and SDO mux are removed.
  - `spi_sdo_out` and `spi_sdo_oe_out` are tied 0.
  - Read transactions still consume N+1 bytes and advance the FSM identically; no register changes.

## Structure
- Package `ad9783_spi_pkg`:
  - state enum;
  - instruction field positions (RW_BIT=7, N_MSB=6, N_LSB=5, ADDR_W=5);
  - REG_COUNT=32;
  - SOFT_RST_ADDR=0x00, SOFT_RST_BIT=5.
- Sub-module `spi_sync_edge`: parameterised synchronizer plus rise/fall pulse generator. Instantiated once each for SCK, CSB and SDI; rise/fall outputs are unused for SDI.

## Test plan
- Write 0x02 (instruction 0x02, data 0xA5) -> one strobe with addr 0x02 / data 0xA5; `loc_data_out`=0xA5 at `loc_addr_in`=0x02.
- Streaming write, instruction 0x65, data 11,22,33,44 -> strobes at 0x05,0x04,0x03,0x02 with those values; then HOLD; extra SCK pulses cause no strobe.
- Read with readback enabled: preload 0x02=0xA5, instruction 0x82 -> SDO bits 1,0,1,0,0,1,0,1 on successive falls; `spi_sdo_oe_out` high for 8 bits only.
- Abort: instruction 0x03, 4 data bits, then CSB high -> no strobe; 0x03 unchanged; state IDLE.
- Wrap and soft reset:
  - instruction 0x21, data 0x77, 0x00 -> 0x01=0x77, 0x00=0x00.
  - then instruction 0x00, data 0x20 -> 0x01 reads 0x00 and bit5 of 0x00 reads 0.
- `rst_in` low during the 3rd data bit -> all outputs at reset values, registers 0x00; the next full transaction completes normally.
